dmem_ctrl: RTL and testbench

//  Data-memory controller on the core's DMem port (dmem_* signals). Accepts one load/store

---
 rtl/dmem_ctrl_pkg.sv | 47 ++++
 rtl/dmem_ctrl_array.sv | 35 +++
 rtl/dmem_ctrl.sv | 110 +++++++++++
 tb/tb_dmem_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared widths, size codes, FSM encodings and byte-lane steering for the data-memory controller.
package dmem_ctrl_pkg;

    localparam int ADDR_SIZE  = 31;
    localparam int INSTR_SIZE = 31;

    localparam logic [1:0] DMEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] DMEM_SZ_HALF = 2'b01;
    localparam logic [1:0] DMEM_SZ_WORD = 2'b10;

    localparam logic [1:0] DMEM_IDLE = 2'b00;
    localparam logic [1:0] DMEM_BUSY = 2'b01;
    localparam logic [1:0] DMEM_RESP = 2'b10;

    typedef struct packed {
        logic        misalign;
        logic [3:0]  we;
        logic [31:0] wdata;
    } lane_t;

    // Replicate the right-justified store data so the lane enables alone pick the target bytes.
    function automatic lane_t steer(input logic [1:0] size, input logic [1:0] ofs,
                                    input logic [31:0] data);
        lane_t s;
        s.misalign = 1'b0;
        s.we       = 4'b0000;
        s.wdata    = data;
        case (size)
            DMEM_SZ_BYTE: begin
                s.we    = 4'b0001 << ofs;
                s.wdata = {4{data[7:0]}};
            end
            DMEM_SZ_HALF: begin
                s.wdata = {2{data[15:0]}};
                if (ofs[0]) s.misalign = 1'b1;
                else        s.we = 4'b0011 << ofs;
            end
            DMEM_SZ_WORD: begin
                if (ofs != 2'b00) s.misalign = 1'b1;
                else              s.we = 4'b1111;
            end
            default: s.misalign = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmem_ctrl_array.sv
// Word-organised synchronous RAM with four byte-lane write enables and a registered read port.
module dmem_ctrl_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = "",
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // The read register only moves on a pure read, so it holds across stores.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          rdata_q <= '0;
        else if (en_i && we_i == 4'b0000)   rdata_q <= mem[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request at a time, fixed access latency, one-cycle ready pulse.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_SIZE:0]    dmem_addr_i,
    input  logic                  dmem_r_enable_i,
    input  logic                  dmem_w_enable_i,
    input  logic [1:0]            dmem_w_size_i,
    input  logic [INSTR_SIZE:0]   dmem_w_data_i,
    output logic [INSTR_SIZE:0]   dmem_r_data_o,
    output logic                  dmem_ready_o,
    output logic                  dmem_misalign_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_SIZE:0]  addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic [INSTR_SIZE:0] wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                mis_q, mis_d;
    logic                access;
    lane_t               lane;
    logic [IDX_W-1:0]    idx;

    assign lane = steer(size_q, addr_q[1:0], wdata_q);
    // Truncating the word address drops the upper bits, so addresses wrap modulo the RAM size.
    assign idx  = IDX_W'(addr_q >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        mis_d   = mis_q;
        access  = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (dmem_r_enable_i || dmem_w_enable_i) begin
                    addr_d  = dmem_addr_i;
                    size_d  = dmem_w_size_i;
                    wdata_d = dmem_w_data_i;
                    wr_d    = dmem_w_enable_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = DMEM_BUSY;
                end
            end
            DMEM_BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    mis_d   = wr_q & lane.misalign;
                    state_d = DMEM_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                mis_d   = 1'b0;
                state_d = DMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
        end
    end

    dmem_ctrl_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .en_i    (access && (!wr_q || !lane.misalign)),
        .we_i    ((access && wr_q) ? lane.we : 4'b0000),
        .idx_i   (idx),
        .wdata_i (lane.wdata),
        .rdata_o (dmem_r_data_o)
    );

    assign dmem_ready_o    = (state_q == DMEM_RESP);
    assign dmem_misalign_o = (state_q == DMEM_RESP) && mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomized checks of dmem_ctrl against a byte-addressed memory model.
module tb_dmem_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic [1:0]  w_size = '0;
    logic [31:0] w_data = '0;
    logic [31:0] r_data;
    logic        ready;
    logic        misalign;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  mem_b [4096];
    logic [31:0] last_rd = '0;

    dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .dmem_addr_i     (addr),
        .dmem_r_enable_i (r_en),
        .dmem_w_enable_i (w_en),
        .dmem_w_size_i   (w_size),
        .dmem_w_data_i   (w_data),
        .dmem_r_data_o   (r_data),
        .dmem_ready_o    (ready),
        .dmem_misalign_o (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        b = int'(a % 4096) & ~3;
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (o % 2) != 0;
        if (sz == 2'd2) return o != 0;
        return 1'b0;
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a,
                                        input logic [31:0] d);
        int b;
        int nbytes;
        b = int'(a % 4096);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) mem_b[b+i] = d[8*i +: 8];
    endfunction

    // One complete transaction; checks latency, misalign, read data and read-data hold while busy.
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] exp_rd;
        bit          exp_mis;
        int          k;
        bit          seen;
        exp_mis = w && model_mis(sz, a);
        exp_rd  = w ? last_rd : model_word(a);
        @(posedge clk); #1;
        addr = a; r_en = r; w_en = w; w_size = sz; w_data = d;
        @(posedge clk);
        #1 addr = $urandom; w_data = $urandom;
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
            check("rdata_hold", r_data, last_rd);
        end
        check("ready_seen", 32'(seen), 32'd1);
        check("latency", 32'(k), 32'(LAT + 1));
        check("misalign", 32'(misalign), 32'(exp_mis));
        check("rdata", r_data, exp_rd);
        r_en = 1'b0; w_en = 1'b0;
        if (w && !exp_mis) model_store(sz, a, d);
        last_rd = exp_rd;
        @(negedge clk);
        check("ready_pulse", {30'd0, ready, misalign}, 32'd0);
    endtask

    initial begin
        logic [31:0] old20;
        logic [31:0] a;
        logic [31:0] exp_rd;
        int          prev;
        int          pulses;

        for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;

        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_rdata", r_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Initialise the first 16 words so every later read has defined contents.
        for (int i = 0; i < 16; i++) access(0, 1, 32'(4 * i), 2'd2, $urandom);

        access(0, 1, 32'h10, 2'd2, 32'hDEAD_BEEF);
        access(1, 0, 32'h10, 2'd0, 32'h0);
        check("t1_word", r_data, 32'hDEAD_BEEF);

        access(0, 1, 32'h10, 2'd2, 32'h0);
        access(0, 1, 32'h13, 2'd0, 32'hFFFF_FFAA);
        access(0, 1, 32'h10, 2'd1, 32'hFFFF_1234);
        access(1, 0, 32'h10, 2'd0, 32'h0);
        check("t2_lanes", r_data, 32'hAA00_1234);

        access(0, 1, 32'h11, 2'd1, 32'h0000_5678);
        access(1, 0, 32'h10, 2'd1, 32'h0);
        check("t3_unchanged", r_data, 32'hAA00_1234);

        // Reset while the store sits in BUSY: nothing commits and ready never pulses.
        access(0, 1, 32'h20, 2'd2, 32'h1111_2222);
        old20 = model_word(32'h20);
        @(posedge clk); #1;
        addr = 32'h20; w_en = 1'b1; w_size = 2'd2; w_data = 32'h55;
        @(posedge clk); #1;
        w_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 5; i++) begin
            check("t4_no_ready", 32'(ready), 32'd0);
            @(negedge clk);
        end
        check("t4_rst_rdata", r_data, 32'd0);
        access(1, 0, 32'h20, 2'd2, 32'h0);
        check("t4_old", r_data, old20);

        access(0, 1, 32'h1004, 2'd2, 32'h77);
        access(1, 0, 32'h4, 2'd2, 32'h0);
        check("t5_wrap", r_data, 32'h77);
        access(1, 1, 32'h8, 2'd2, 32'hCAFE_F00D);
        access(1, 0, 32'h8, 2'd2, 32'h0);
        check("t5_rw_store", r_data, 32'hCAFE_F00D);

        // Enables held high; the address is switched at each ready so successive reads differ.
        @(posedge clk); #1;
        a = 32'h10; addr = a; r_en = 1'b1; w_en = 1'b0;
        exp_rd = model_word(a);
        prev = 0; pulses = 0;
        for (int k = 0; k < 40 && pulses < 4; k++) begin
            @(negedge clk);
            if (ready) begin
                if (pulses > 0) check("t6_period", 32'(k - prev), 32'(LAT + 2));
                check("t6_rdata", r_data, exp_rd);
                last_rd = exp_rd;
                prev = k;
                pulses++;
                a = (a == 32'h10) ? 32'h8 : 32'h10;
                addr = a;
                exp_rd = model_word(a);
            end else begin
                check("t6_hold", r_data, last_rd);
            end
        end
        r_en = 1'b0;
        check("t6_pulses", 32'(pulses), 32'd4);
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) access(1, 0, a, 2'($urandom), $urandom);
            else access($urandom_range(0, 1) == 1, 1, a, 2'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
